// File: rtl/phase_meas_pkg.sv
// -----------------------------------------------------------------------------
// phase_meas_pkg
// Shared definitions for the phase-interval measurement block:
//   PHASE_COUNT  - phase steps per coarse clock cycle (7 PLL taps, two edges)
//   meas_state_e - measurement FSM states
//   phase_idx_t  - decoded phase index, 0..13
//   popcount7    - number of ones in a 7-bit PLL snapshot
//   thermo_code  - the single legal snapshot for a given phase index
// -----------------------------------------------------------------------------
package phase_meas_pkg;

  localparam int PHASE_COUNT = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } meas_state_e;

  typedef logic [3:0] phase_idx_t;

  function automatic logic [2:0] popcount7(input logic [6:0] code);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < 7; i++) begin
      cnt = cnt + {2'b00, code[i]};
    end
    return cnt;
  endfunction

  // Indices 0..6: a run of ones growing down from PLL0 (bit 6).
  // Indices 7..13: that run draining away from PLL0.
  function automatic logic [6:0] thermo_code(input phase_idx_t idx);
    if (idx < 4'd7) begin
      return 7'h7f << (4'd6 - idx);
    end
    return 7'h7f >> (idx - 4'd6);
  endfunction

endpackage

// File: rtl/phase_code_decoder.sv
// -----------------------------------------------------------------------------
// phase_code_decoder
// Combinational decode of a 7-bit PLL phase snapshot into a phase index.
//   code_i    - snapshot, PLL0 in bit 6
//   idx_o     - phase index 0..13
//   illegal_o - snapshot is not one of the 14 thermometer codes
// Build option: PHASE_BUBBLE_CORRECT_EN - tolerate bubbles by decoding any
// code from its popcount; illegal_o is then never raised.
// -----------------------------------------------------------------------------
module phase_code_decoder
  import phase_meas_pkg::*;
(
  input  logic [6:0] code_i,
  output phase_idx_t idx_o,
  output logic       illegal_o
);

  logic [2:0] ones;

  assign ones = popcount7(code_i);

  // For legal codes the popcount alone fixes the index; bit 6 says whether
  // the run of ones is growing (first half) or draining (second half).
  always_comb begin
    if (code_i[6]) begin
      idx_o = {1'b0, ones} - 4'd1;
    end else begin
      idx_o = 4'd13 - {1'b0, ones};
    end
  end

`ifdef PHASE_BUBBLE_CORRECT_EN
  assign illegal_o = 1'b0;
`else
  assign illegal_o = (code_i != thermo_code(idx_o));
`endif

endmodule

// File: rtl/phase_interval_decoder.sv
// -----------------------------------------------------------------------------
// phase_interval_decoder
// Measures the interval between a start and a stop event in 1/14-cycle units
// from a coarse cycle counter plus the PLL phase snapshots at both events.
//   Clock, Reset_n        - clock (rising edge), synchronous active-low reset
//   StartValid/StartCode  - start strobe and phase snapshot
//   StopValid/StopCode    - stop strobe and phase snapshot
//   Abort                 - cancel a measurement in progress
//   Busy                  - measurement armed or result in flight
//   ResultValid           - one-cycle result strobe, 2 cycles after stop
//   Interval              - N*14 + stopIdx - startIdx (held between results)
//   CodeError, Overflow   - result qualifiers (held between results)
// Build option: PHASE_BUBBLE_CORRECT_EN (see phase_code_decoder).
// -----------------------------------------------------------------------------
module phase_interval_decoder
  import phase_meas_pkg::*;
#(
  parameter int COARSE_W   = 16,
  parameter int INTERVAL_W = COARSE_W + 4
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  StartValid,
  input  logic [6:0]            StartCode,
  input  logic                  StopValid,
  input  logic [6:0]            StopCode,
  input  logic                  Abort,
  output logic                  Busy,
  output logic                  ResultValid,
  output logic [INTERVAL_W-1:0] Interval,
  output logic                  CodeError,
  output logic                  Overflow
);

  localparam logic [COARSE_W-1:0] CNT_MAX  = '1;
  localparam logic [COARSE_W-1:0] CNT_LAST = CNT_MAX - 1'b1;

  phase_idx_t start_idx, stop_idx;
  logic       start_illegal, stop_illegal;

  phase_code_decoder u_start_dec (
    .code_i    (StartCode),
    .idx_o     (start_idx),
    .illegal_o (start_illegal)
  );

  phase_code_decoder u_stop_dec (
    .code_i    (StopCode),
    .idx_o     (stop_idx),
    .illegal_o (stop_illegal)
  );

  meas_state_e         state_q;
  logic [COARSE_W-1:0] cnt_q;
  phase_idx_t          start_idx_q;
  logic                start_err_q;

  // Decode-stage register, loaded on the stop (or overflow) edge.
  logic                p1_valid_q;
  logic                p1_ovf_q;
  logic                p1_err_q;
  logic [COARSE_W-1:0] p1_n_q;
  phase_idx_t          p1_stop_q;

  // NOTE: state registers use non-blocking assignments so every always_ff
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      start_idx_q <= '0;
      start_err_q <= 1'b0;
      p1_valid_q  <= 1'b0;
      p1_ovf_q    <= 1'b0;
      p1_err_q    <= 1'b0;
      p1_n_q      <= '0;
      p1_stop_q   <= '0;
    end else begin
      p1_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A coincident stop is simply not looked at here.
          if (StartValid) begin
            state_q     <= ARMED;
            cnt_q       <= '0;
            start_idx_q <= start_idx;
            start_err_q <= start_illegal;
          end
        end
        ARMED: begin
          if (Abort) begin
            state_q <= IDLE;
          end else if (StopValid) begin
            state_q    <= DONE;
            p1_valid_q <= 1'b1;
            p1_ovf_q   <= 1'b0;
            p1_err_q   <= start_err_q | stop_illegal;
            p1_n_q     <= cnt_q;
            p1_stop_q  <= stop_idx;
          end else if (cnt_q == CNT_LAST) begin
            // This increment saturates the counter: end the measurement.
            state_q    <= DONE;
            cnt_q      <= CNT_MAX;
            p1_valid_q <= 1'b1;
            p1_ovf_q   <= 1'b1;
            p1_err_q   <= 1'b0;
            p1_n_q     <= CNT_MAX;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Busy = (state_q != IDLE);

  // start_idx_q cannot change while a result is in flight: a new start is
  // only accepted in IDLE, which follows the arithmetic stage.
  logic [INTERVAL_W-1:0] base_d;
  logic [INTERVAL_W-1:0] interval_d;
  logic                  neg_d;

  // NOTE: every always_comb output gets a value on every path, so no latch
  // can be inferred.
  always_comb begin
    base_d     = INTERVAL_W'(p1_n_q) * INTERVAL_W'(PHASE_COUNT)
               + INTERVAL_W'(p1_stop_q);
    neg_d      = (base_d < INTERVAL_W'(start_idx_q));
    interval_d = base_d - INTERVAL_W'(start_idx_q);
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      ResultValid <= 1'b0;
      Interval    <= '0;
      CodeError   <= 1'b0;
      Overflow    <= 1'b0;
    end else begin
      ResultValid <= p1_valid_q;
      if (p1_valid_q) begin
        Overflow <= p1_ovf_q;
        if (p1_ovf_q) begin
          Interval  <= '1;
          CodeError <= 1'b0;
        end else if (p1_err_q || neg_d) begin
          Interval  <= '0;
          CodeError <= 1'b1;
        end else begin
          Interval  <= interval_d;
          CodeError <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_phase_interval_decoder.sv
// -----------------------------------------------------------------------------
// tb_phase_interval_decoder
// Two DUTs share one stimulus stream: dut0 with default widths, dut1 with
// COARSE_W=4 so counter saturation is reachable. A measurement-level model
// predicts every output of both each cycle; directed tests add literal
// expectations. Build option PHASE_BUBBLE_CORRECT_EN selects the expected
// decoding of illegal snapshots.
// -----------------------------------------------------------------------------
module tb_phase_interval_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_valid, stop_valid, abort;
  logic [6:0] start_code, stop_code;

  logic        busy0, rv0, err0, ovf0;
  logic [19:0] int0;
  logic        busy1, rv1, err1, ovf1;
  logic [7:0]  int1;

  always #5 clk = ~clk;

  phase_interval_decoder dut0 (
    .Clock(clk), .Reset_n(rst_n),
    .StartValid(start_valid), .StartCode(start_code),
    .StopValid(stop_valid), .StopCode(stop_code), .Abort(abort),
    .Busy(busy0), .ResultValid(rv0), .Interval(int0),
    .CodeError(err0), .Overflow(ovf0)
  );

  phase_interval_decoder #(.COARSE_W(4)) dut1 (
    .Clock(clk), .Reset_n(rst_n),
    .StartValid(start_valid), .StartCode(start_code),
    .StopValid(stop_valid), .StopCode(stop_code), .Abort(abort),
    .Busy(busy1), .ResultValid(rv1), .Interval(int1),
    .CodeError(err1), .Overflow(ovf1)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // ---------------- behavioural model ----------------
`ifndef PHASE_BUBBLE_CORRECT_EN
  logic [6:0] legal_codes [0:13] = '{
    7'b1000000, 7'b1100000, 7'b1110000, 7'b1111000, 7'b1111100,
    7'b1111110, 7'b1111111, 7'b0111111, 7'b0011111, 7'b0001111,
    7'b0000111, 7'b0000011, 7'b0000001, 7'b0000000 };
`endif

  function automatic void decode(input logic [6:0] c, output int idx, output bit bad);
`ifdef PHASE_BUBBLE_CORRECT_EN
    int p;
    p   = $countones(c);
    bad = 1'b0;
    idx = c[6] ? p - 1 : 13 - p;
`else
    bad = 1'b1;
    idx = 0;
    for (int j = 0; j < 14; j++) begin
      if (c == legal_codes[j]) begin
        idx = j;
        bad = 1'b0;
      end
    end
`endif
  endfunction

  // mode: 0 idle, 1 armed, 2 result being computed
  int m_mode[2], m_k[2], m_start_idx[2];
  bit m_start_bad[2];
  bit m_pend[2], m_pend_err[2], m_pend_ovf[2];
  int m_pend_int[2];
  bit m_rv[2], m_err[2], m_ovf[2];
  int m_int[2];
  int armed_limit[2] = '{65535, 15};
  int all_ones[2]    = '{(1 << 20) - 1, 255};

  task automatic model_step(input int i);
    int  pi, val;
    bit  pb;
    if (!rst_n) begin
      m_mode[i] = 0; m_pend[i] = 0; m_rv[i] = 0;
      m_int[i] = 0; m_err[i] = 0; m_ovf[i] = 0;
      return;
    end
    m_rv[i] = 0;
    if (m_pend[i]) begin
      m_rv[i]  = 1;
      m_int[i] = m_pend_int[i];
      m_err[i] = m_pend_err[i];
      m_ovf[i] = m_pend_ovf[i];
      m_pend[i] = 0;
    end
    case (m_mode[i])
      0: if (start_valid) begin
        decode(start_code, m_start_idx[i], m_start_bad[i]);
        m_k[i] = 0;
        m_mode[i] = 1;
      end
      1: begin
        m_k[i]++;   // edges seen since start; N at a stop is m_k-1
        if (abort) begin
          m_mode[i] = 0;
        end else if (stop_valid) begin
          decode(stop_code, pi, pb);
          val = (m_k[i] - 1) * 14 + pi - m_start_idx[i];
          m_pend[i] = 1; m_pend_ovf[i] = 0;
          if (pb || m_start_bad[i] || val < 0) begin
            m_pend_err[i] = 1; m_pend_int[i] = 0;
          end else begin
            m_pend_err[i] = 0; m_pend_int[i] = val;
          end
          m_mode[i] = 2;
        end else if (m_k[i] == armed_limit[i]) begin
          m_pend[i] = 1; m_pend_ovf[i] = 1;
          m_pend_err[i] = 0; m_pend_int[i] = all_ones[i];
          m_mode[i] = 2;
        end
      end
      default: m_mode[i] = 0;
    endcase
  endtask

  initial forever begin
    @(posedge clk);
    model_step(0);
    model_step(1);
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    check("m0 busy", 32'(busy0), 32'(m_mode[0] != 0));
    check("m0 rv",   32'(rv0),   32'(m_rv[0]));
    check("m0 int",  32'(int0),  32'(m_int[0]));
    check("m0 err",  32'(err0),  32'(m_err[0]));
    check("m0 ovf",  32'(ovf0),  32'(m_ovf[0]));
    check("m1 busy", 32'(busy1), 32'(m_mode[1] != 0));
    check("m1 rv",   32'(rv1),   32'(m_rv[1]));
    check("m1 int",  32'(int1),  32'(m_int[1]));
    check("m1 err",  32'(err1),  32'(m_err[1]));
    check("m1 ovf",  32'(ovf1),  32'(m_ovf[1]));
  end

  // ---------------- directed stimulus ----------------
  // Start now; stop sampled after n ARMED cycles, so N = n.
  task automatic measure(input logic [6:0] sc, input logic [6:0] pc, input int n, input bit ab);
    start_valid = 1'b1; start_code = sc;
    tick();
    start_valid = 1'b0;
    repeat (n) tick();
    stop_valid = 1'b1; stop_code = pc; abort = ab;
    tick();
    stop_valid = 1'b0; abort = 1'b0;
  endtask

  // Called one cycle after the stop edge; result appears in the next cycle.
  task automatic expect_result(input string name, input logic [31:0] e_int, input bit e_err);
    check({name, " rv early"}, 32'(rv0), 32'd0);
    tick();
    check({name, " rv0"},  32'(rv0),  32'd1);
    check({name, " int0"}, 32'(int0), e_int);
    check({name, " err0"}, 32'(err0), 32'(e_err));
    check({name, " ovf0"}, 32'(ovf0), 32'd0);
    check({name, " rv1"},  32'(rv1),  32'd1);
    check({name, " int1"}, 32'(int1), e_int);
    check({name, " err1"}, 32'(err1), 32'(e_err));
    tick();
    check({name, " rv after"},  32'(rv0),  32'd0);
    check({name, " int held"},  32'(int0), e_int);
  endtask

  initial begin
    rst_n = 1'b0; start_valid = 1'b0; stop_valid = 1'b0; abort = 1'b0;
    start_code = 7'd0; stop_code = 7'd0;
    repeat (3) tick();
    check("reset busy", 32'(busy0), 32'd0);
    check("reset rv",   32'(rv0),   32'd0);
    check("reset int",  32'(int0),  32'd0);
    check("reset err",  32'(err0),  32'd0);
    check("reset ovf",  32'(ovf0),  32'd0);
    rst_n = 1'b1;
    tick();

    // Stop while idle is ignored.
    stop_valid = 1'b1; stop_code = 7'b0000111;
    tick();
    stop_valid = 1'b0;
    check("idle stop busy", 32'(busy0), 32'd0);
    repeat (3) tick();

    // N=4, 1000000 -> 0000111: 4*14 + 10 - 0 = 66
    measure(7'b1000000, 7'b0000111, 4, 1'b0);
    expect_result("n4", 32'd66, 1'b0);

    // N=0, stop index 1 < start index 6: negative
    measure(7'b1111111, 7'b1100000, 0, 1'b0);
    expect_result("neg", 32'd0, 1'b1);

    // N=0, equal indices: zero interval, not an error
    measure(7'b1111110, 7'b1111110, 0, 1'b0);
    expect_result("zero", 32'd0, 1'b0);

    // Start and stop together in IDLE: start only; a later start is ignored.
    // start idx 12, N=3, stop idx 11: 42 + 11 - 12 = 41
    start_valid = 1'b1; start_code = 7'b0000001;
    stop_valid = 1'b1; stop_code = 7'b0000000;
    tick();
    start_valid = 1'b0; stop_valid = 1'b0;
    check("both busy", 32'(busy0), 32'd1);
    tick();
    start_valid = 1'b1; start_code = 7'b1111111;
    tick();
    start_valid = 1'b0;
    tick();
    stop_valid = 1'b1; stop_code = 7'b0000011;
    tick();
    stop_valid = 1'b0;
    expect_result("both", 32'd41, 1'b0);

    // Abort wins over a coincident stop.
    measure(7'b0000000, 7'b0000001, 2, 1'b1);
    check("abort busy", 32'(busy0), 32'd0);
    repeat (2) tick();
    check("abort no rv", 32'(rv0), 32'd0);

    // Bubbled start code 1010000, N=2, stop idx 0
`ifdef PHASE_BUBBLE_CORRECT_EN
    measure(7'b1010000, 7'b1000000, 2, 1'b0);
    expect_result("bubble", 32'd27, 1'b0);
`else
    measure(7'b1010000, 7'b1000000, 2, 1'b0);
    expect_result("bubble", 32'd0, 1'b1);
`endif

    // N=14 on the 4-bit counter: stop beats saturation. 196 + 13 - 0 = 209
    measure(7'b1000000, 7'b0000000, 14, 1'b0);
    check("n14 ovf1", 32'(ovf1), 32'd0);
    expect_result("n14", 32'd209, 1'b0);

    // No stop: dut1 saturates after 15 ARMED cycles.
    start_valid = 1'b1; start_code = 7'b1000000;
    tick();
    start_valid = 1'b0;
    repeat (15) tick();
    check("sat rv early", 32'(rv1), 32'd0);
    tick();
    check("sat rv1",  32'(rv1),  32'd1);
    check("sat ovf1", 32'(ovf1), 32'd1);
    check("sat int1", 32'(int1), 32'd255);
    check("sat err1", 32'(err1), 32'd0);
    check("sat dut0 busy", 32'(busy0), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("sat abort busy0", 32'(busy0), 32'd0);
    tick();

    // Reset for one cycle while armed discards the measurement.
    start_valid = 1'b1; start_code = 7'b1000000;
    tick();
    start_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    check("mid reset busy", 32'(busy0), 32'd0);
    check("mid reset int",  32'(int0),  32'd0);
    check("mid reset ovf1", 32'(ovf1),  32'd0);
    rst_n = 1'b1;
    repeat (4) tick();
    check("mid reset no rv", 32'(rv0), 32'd0);
    // start idx 9, N=1, stop idx 13: 14 + 13 - 9 = 18
    measure(7'b0001111, 7'b0000000, 1, 1'b0);
    expect_result("post reset", 32'd18, 1'b0);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected end before 100000 ns");
    $fatal(1);
  end

endmodule
